// File: rtl/rv32_pkg.sv
// Shared register-file writeback types: data/address widths and the writeback entry.
package rv32_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [XLEN-1:0]   xdata_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  // One pending register write; live=0 means the slot carries no write.
  typedef struct packed {
    logic      live;
    reg_addr_t rd;
    xdata_t    data;
  } wb_entry_t;

  // One-hot decode of a register address into a per-register mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(reg_addr_t r);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_ldq.sv
// Load writeback queue: circular buffer of writeback entries with a per-entry live bit,
// a kill-by-rd port for write-after-write suppression, and all entries exposed in age order.
module wb_ldq
  import rv32_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  input  logic                  kill_i,
  input  reg_addr_t             kill_rd_i,
  output logic                  full_o,
  output logic                  empty_o,
  output wb_entry_t             head_o,
  output wb_entry_t [Depth-1:0] age_entry_o,
  output logic      [Depth-1:0] age_valid_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  wb_entry_t [Depth-1:0] mem_q, mem_d;
  logic                  push_ok;
  logic                  pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Next-state: kill matching stored entries first, then write the new entry into the free slot,
  // so a same-cycle push to the killed register stays live.
  always_comb begin
    mem_d = mem_q;
    if (kill_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (mem_q[i].rd == kill_rd_i) begin
          mem_d[i].live = 1'b0;
        end
      end
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry_i;
    end
    // Depth is a power of two, so pointer overflow wraps modulo Depth.
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    cnt_d    = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  // Queue state registers; reset discards every queued entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Age-ordered view: index 0 is the head (oldest), higher indices are younger.
  for (genvar g = 0; g < Depth; g++) begin : g_age
    logic [PtrW-1:0] idx;
    assign idx            = rd_ptr_q + PtrW'(g);
    assign age_entry_o[g] = mem_q[idx];
    assign age_valid_o[g] = (CntW'(g) < cnt_q);
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback controller: merges never-stalled ALU writebacks and queued load
// writebacks into the single write port, kills stale queued loads on WAW, and forwards
// pending values to two read operands.
module regfile_wb_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                alu_valid_i,
  input  logic [REG_AW-1:0]   alu_rd_i,
  input  logic [XLEN-1:0]     alu_data_i,
  input  logic                ld_valid_i,
  output logic                ld_ready_o,
  input  logic [REG_AW-1:0]   ld_rd_i,
  input  logic [XLEN-1:0]     ld_data_i,
  output logic                rf_we_o,
  output logic [REG_AW-1:0]   rf_rd_o,
  output logic [XLEN-1:0]     rf_wdata_o,
  input  logic [REG_AW-1:0]   rs1_i,
  input  logic [REG_AW-1:0]   rs2_i,
  output logic                fwd1_hit_o,
  output logic [XLEN-1:0]     fwd1_data_o,
  output logic                fwd2_hit_o,
  output logic [XLEN-1:0]     fwd2_data_o,
  output logic [NUM_REGS-1:0] busy_o
);

  wb_entry_t             out_q, out_d;
  wb_entry_t             head;
  wb_entry_t [Depth-1:0] age_entry;
  logic      [Depth-1:0] age_valid;
  logic                  q_full;
  logic                  q_empty;
  logic                  alu_sel;
  logic                  q_pop;
  logic                  q_push;
  wb_entry_t             push_entry;

  // ALU wins the port whenever it has a real destination; x0 writes are ignored.
  assign alu_sel    = alu_valid_i && (alu_rd_i != '0);
  assign q_pop      = !alu_sel && !q_empty;
  assign ld_ready_o = !q_full;
  // Loads to x0 are accepted but never enter the queue.
  assign q_push     = ld_valid_i && !q_full && (ld_rd_i != '0);
  assign push_entry = '{live: 1'b1, rd: ld_rd_i, data: ld_data_i};

  wb_ldq #(
    .Depth(Depth)
  ) u_ldq (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (q_push),
    .push_entry_i(push_entry),
    .pop_i       (q_pop),
    .kill_i      (alu_sel),
    .kill_rd_i   (alu_rd_i),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_o      (head),
    .age_entry_o (age_entry),
    .age_valid_o (age_valid)
  );

  // Select the write for next cycle: ALU, else live head; a dead head is popped silently.
  always_comb begin
    out_d = '0;
    if (alu_sel) begin
      out_d = '{live: 1'b1, rd: alu_rd_i, data: alu_data_i};
    end else if (!q_empty && head.live) begin
      out_d = head;
    end
  end

  // Registered write-port stage; out_q.live doubles as the write enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign rf_we_o    = out_q.live;
  assign rf_rd_o    = out_q.rd;
  assign rf_wdata_o = out_q.data;

  reg_addr_t [1:0] rs_sel;
  logic      [1:0] fwd_hit;
  xdata_t    [1:0] fwd_data;

  assign rs_sel[0]   = rs1_i;
  assign rs_sel[1]   = rs2_i;
  assign fwd1_hit_o  = fwd_hit[0];
  assign fwd1_data_o = fwd_data[0];
  assign fwd2_hit_o  = fwd_hit[1];
  assign fwd2_data_o = fwd_data[1];

  for (genvar k = 0; k < 2; k++) begin : g_fwd
    // Forward the newest pending value: ALU input, then youngest live queue entry, then output stage.
    always_comb begin
      fwd_hit[k]  = 1'b0;
      fwd_data[k] = '0;
      if (rs_sel[k] != '0) begin
        if (alu_valid_i && (alu_rd_i == rs_sel[k])) begin
          fwd_hit[k]  = 1'b1;
          fwd_data[k] = alu_data_i;
        end else begin
          // Later iterations are younger, so the last match wins.
          for (int unsigned i = 0; i < Depth; i++) begin
            if (age_valid[i] && age_entry[i].live && (age_entry[i].rd == rs_sel[k])) begin
              fwd_hit[k]  = 1'b1;
              fwd_data[k] = age_entry[i].data;
            end
          end
          if (!fwd_hit[k] && out_q.live && (out_q.rd == rs_sel[k])) begin
            fwd_hit[k]  = 1'b1;
            fwd_data[k] = out_q.data;
          end
        end
      end
    end
  end

  // Scoreboard of registers with a write still in flight (queue or output stage).
  always_comb begin
    busy_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (age_valid[i] && age_entry[i].live) begin
        busy_o = busy_o | reg_onehot(age_entry[i].rd);
      end
    end
    if (out_q.live) begin
      busy_o = busy_o | reg_onehot(out_q.rd);
    end
    busy_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_regfile_wb_ctrl;

  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [31:0] busy;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(
    .Depth(Depth)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .alu_valid_i(alu_valid),
    .alu_rd_i   (alu_rd),
    .alu_data_i (alu_data),
    .ld_valid_i (ld_valid),
    .ld_ready_o (ld_ready),
    .ld_rd_i    (ld_rd),
    .ld_data_i  (ld_data),
    .rf_we_o    (rf_we),
    .rf_rd_o    (rf_rd),
    .rf_wdata_o (rf_wdata),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .fwd1_hit_o (fwd1_hit),
    .fwd1_data_o(fwd1_data),
    .fwd2_hit_o (fwd2_hit),
    .fwd2_data_o(fwd2_data),
    .busy_o     (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: pending loads in arrival order, plus the write visible on the port.
  typedef struct {
    bit          live;
    int unsigned rd;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  bit          m_we;
  int unsigned m_rd;
  logic [31:0] m_data;

  function automatic void model_clear();
    mq.delete();
    m_we   = 1'b0;
    m_rd   = 0;
    m_data = '0;
  endfunction

  function automatic void model_fwd(input int unsigned rs, output bit hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs == 0) return;
    if (alu_valid && int'(alu_rd) == rs) begin
      hit = 1'b1;
      d   = alu_data;
      return;
    end
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].live && mq[i].rd == rs) begin
        hit = 1'b1;
        d   = mq[i].data;
        return;
      end
    end
    if (m_we && m_rd == rs) begin
      hit = 1'b1;
      d   = m_data;
    end
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    foreach (mq[i]) if (mq[i].live) b[mq[i].rd] = 1'b1;
    if (m_we) b[m_rd] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  // Apply one clock edge of the behavioural rules to the model, using the current inputs.
  function automatic void model_edge();
    bit          alu_w;
    bit          ready;
    bit          n_we;
    int unsigned n_rd;
    logic [31:0] n_data;
    ment_t       e;
    alu_w  = alu_valid && (alu_rd != 0);
    ready  = (mq.size() < Depth);
    n_we   = 1'b0;
    n_rd   = 0;
    n_data = '0;
    if (alu_w) begin
      n_we   = 1'b1;
      n_rd   = alu_rd;
      n_data = alu_data;
      foreach (mq[i]) if (mq[i].rd == int'(alu_rd)) mq[i].live = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live) begin
        n_we   = 1'b1;
        n_rd   = e.rd;
        n_data = e.data;
      end
    end
    if (ld_valid && ready && ld_rd != 0) mq.push_back('{live: 1'b1, rd: ld_rd, data: ld_data});
    m_we   = n_we;
    m_rd   = n_rd;
    m_data = n_data;
  endfunction

  task automatic compare_all();
    bit          h;
    logic [31:0] d;
    check_eq("rf_we", rf_we, m_we);
    if (m_we) begin
      check_eq("rf_rd", rf_rd, m_rd);
      check_eq("rf_wdata", rf_wdata, m_data);
    end
    check_eq("rd0_write", rf_we && (rf_rd == 5'd0), 0);
    check_eq("ld_ready", ld_ready, mq.size() < Depth);
    check_eq("busy", busy, model_busy());
    model_fwd(rs1, h, d);
    check_eq("fwd1_hit", fwd1_hit, h);
    check_eq("fwd1_data", fwd1_data, d);
    model_fwd(rs2, h, d);
    check_eq("fwd2_hit", fwd2_hit, h);
    check_eq("fwd2_data", fwd2_data, d);
  endtask

  task automatic set_in(input bit av, input int ard, input logic [31:0] ad,
                        input bit lv, input int lrd, input logic [31:0] ld,
                        input int r1, input int r2);
    alu_valid = av;
    alu_rd    = 5'(ard);
    alu_data  = ad;
    ld_valid  = lv;
    ld_rd     = 5'(lrd);
    ld_data   = ld;
    rs1       = 5'(r1);
    rs2       = 5'(r2);
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic half_a();
    @(negedge clk);
    compare_all();
  endtask

  task automatic half_b();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_in();
    set_in($urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom,
           $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  // Assert reset in the middle of traffic; called just after a rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("rst_rf_we", rf_we, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ld_ready", ld_ready, 1);
      check_eq("rst_rf_rd", rf_rd, 0);
      check_eq("rst_rf_wdata", rf_wdata, 0);
      @(posedge clk);
      #1;
      rand_in();
    end
    idle_in();
    rst_n = 1'b1;
    half_a();
    check_eq("post_rst_we", rf_we, 0);
    half_b();
  endtask

  initial begin
    bit          seen;
    bit          bad;
    logic [31:0] got_data;
    int          accepted;
    int          ld_seen;
    rst_n = 1'b0;
    idle_in();
    model_clear();
    #2;
    check_eq("init_rf_we", rf_we, 0);
    check_eq("init_busy", busy, 0);
    check_eq("init_ld_ready", ld_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    half_a();
    check_eq("init_post_we", rf_we, 0);
    half_b();

    // Lone load x5=0x11 reaches the write port, then busy[5] drops.
    set_in(0, 0, 0, 1, 5, 32'h11, 5, 0);
    half_a();
    half_b();
    idle_in();
    seen     = 1'b0;
    got_data = '0;
    for (int c = 0; c < 5; c++) begin
      half_a();
      if (rf_we && rf_rd == 5'd5) begin
        seen     = 1'b1;
        got_data = rf_wdata;
      end
      half_b();
    end
    check_eq("lone_seen", seen, 1);
    check_eq("lone_data", got_data, 32'h11);
    @(negedge clk);
    check_eq("lone_busy5", busy[5], 0);
    half_b();

    // Contention: 6 ALU writes while 5 loads (x10..x14) are offered.
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      set_in(1, c + 1, 32'h100 + c, accepted < 5, 10 + accepted, 32'h200 + accepted, 0, 0);
      half_a();
      if (accepted == 4) check_eq("ldq_full", ld_ready, 0);
      if (ld_valid && ld_ready) accepted++;
      half_b();
    end
    ld_seen = 0;
    bad     = 1'b0;
    for (int c = 0; c < 16; c++) begin
      set_in(0, 0, 0, accepted < 5, 10 + accepted, 32'h200 + accepted, 0, 0);
      half_a();
      if (ld_valid && ld_ready) accepted++;
      if (rf_we && rf_rd >= 5'd10) begin
        if (int'(rf_rd) != 10 + ld_seen || rf_wdata != 32'h200 + ld_seen) bad = 1'b1;
        ld_seen++;
      end
      half_b();
    end
    check_eq("ld_order_ok", bad, 0);
    check_eq("ld_count", ld_seen, 5);

    // WAW: queued load x7=0xAA is overtaken by ALU x7=0xBB.
    set_in(1, 1, 32'h1, 1, 7, 32'hAA, 7, 0);
    half_a();
    half_b();
    set_in(1, 7, 32'hBB, 0, 0, 0, 7, 0);
    half_a();
    half_b();
    idle_in();
    bad      = 1'b0;
    got_data = '0;
    for (int c = 0; c < 5; c++) begin
      half_a();
      if (rf_we && rf_rd == 5'd7) begin
        if (rf_wdata == 32'hAA) bad = 1'b1;
        got_data = rf_wdata;
      end
      half_b();
    end
    check_eq("waw_no_stale", bad, 0);
    check_eq("waw_final", got_data, 32'hBB);
    @(negedge clk);
    check_eq("waw_busy7", busy[7], 0);
    half_b();

    // Forwarding: two live loads to x9 held behind ALU traffic.
    set_in(1, 1, 32'h5, 1, 9, 32'h1, 0, 0);
    half_a();
    half_b();
    set_in(1, 2, 32'h6, 1, 9, 32'h2, 0, 0);
    half_a();
    half_b();
    set_in(1, 3, 32'h7, 0, 0, 0, 9, 0);
    half_a();
    check_eq("fwd_young_hit", fwd1_hit, 1);
    check_eq("fwd_young_data", fwd1_data, 32'h2);
    half_b();
    set_in(1, 9, 32'h3, 0, 0, 0, 9, 9);
    half_a();
    check_eq("fwd_alu_data", fwd1_data, 32'h3);
    check_eq("fwd_alu_data2", fwd2_data, 32'h3);
    half_b();
    idle_in();
    for (int c = 0; c < 6; c++) begin
      half_a();
      half_b();
    end

    // x0 traffic never writes or forwards.
    for (int c = 0; c < 4; c++) begin
      set_in(1, 0, $urandom, 1, 0, $urandom, 0, 0);
      half_a();
      check_eq("x0_fwd1", fwd1_hit, 0);
      check_eq("x0_fwd2", fwd2_hit, 0);
      half_b();
    end

    // Randomized traffic with a reset in the middle.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      rand_in();
      half_a();
      half_b();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
